button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter NUM_BTN, default 8, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a change (10 ms at 100 MHz); legal range 2..2^24.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000, hold cycles before the first auto-repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-005 SHALL have port Clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port Rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port Switch, input, NUM_BTN, raw asynchronous push buttons, active-low.
REQ-008 SHALL have port Pressed, output, NUM_BTN, debounced button level, active-high.
REQ-009 SHALL have port PressPulse, output, NUM_BTN, one-cycle strobe per accepted press, plus auto-repeat strobes when enabled.
REQ-010 SHALL have port ReleasePulse, output, NUM_BTN, one-cycle strobe per accepted release.

Function
REQ-011 SHALL pass each Switch bit through a 2-flop synchronizer and invert it before use; the inverted synchronized value is "act".
REQ-012 SHALL give every channel its own FSM and counter; channels SHALL be fully independent.
REQ-013 FSM states SHALL be IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-014 IDLE: act=1 -> PRESS_WAIT with counter cleared; otherwise stay in IDLE.
REQ-015 PRESS_WAIT: act=0 -> IDLE (bounce rejected, no pulse); counter == DEBOUNCE_CYCLES-1 with act=1 -> HELD; otherwise counter increments.
REQ-016 On the PRESS_WAIT->HELD edge, Pressed SHALL rise and PressPulse SHALL be high for exactly one cycle.
REQ-017 HELD: act=0 -> REL_WAIT with counter cleared.
REQ-018 REL_WAIT: act=1 -> HELD (no pulse); counter == DEBOUNCE_CYCLES-1 with act=0 -> IDLE, Pressed falls, and ReleasePulse is high for one cycle.
REQ-019 Latency: with Switch held low from edge k onward, PressPulse SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2; release latency SHALL be symmetric.
REQ-020 Any act glitch inside a wait state SHALL restart qualification from zero on the next entry to that state.
REQ-021 All outputs SHALL be registered; PressPulse and ReleasePulse SHALL never be high in the same cycle for one channel.
REQ-022 Counters SHALL saturate and never wrap; width SHALL be clog2 of the largest count parameter.

Reset
REQ-023 With Rst=1 at a clock edge, all FSMs SHALL go to IDLE, and counters, synchronizer flops, Pressed, PressPulse and ReleasePulse SHALL all go to 0.
REQ-024 A button held through reset SHALL be re-qualified as a new press after Rst falls, taking the full REQ-019 latency.
REQ-025 Reset asserted mid-pulse SHALL clear the pulse in the following cycle.

Configuration
REQ-026 Macro BUTTON_AUTOREPEAT_EN defined: in HELD, a per-channel repeat counter SHALL issue one PressPulse after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until the channel leaves HELD.
REQ-027 Entering REL_WAIT SHALL clear the repeat counter; a return from REL_WAIT to HELD SHALL restart from REPEAT_DELAY.
REQ-028 Macro undefined: no repeat logic SHALL be present; PressPulse SHALL fire exactly once per press.

Structure
REQ-029 Package btn_pkg SHALL hold the FSM state encoding (2-bit, IDLE=0, PRESS_WAIT=1, HELD=2, REL_WAIT=3) and the counter-width function.
REQ-030 Sub-module button_debounce_ch SHALL implement one channel (synchronizer, FSM, counters); the top SHALL instantiate NUM_BTN copies in a generate loop.

Verification (sim parameters: DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_PERIOD=20)
REQ-031 Switch[0] low, held steady from edge 10 -> PressPulse[0] one cycle after edge 28; Pressed[0]=1 from then on; all other bits 0.
REQ-032 Switch[3] toggled every 5 cycles for 100 cycles, then held high -> no PressPulse[3], no ReleasePulse[3], Pressed[3]=0 throughout.
REQ-033 Press Switch[7] stable, then release with a 3-cycle low glitch at release+8 -> exactly one ReleasePulse[7], 16 cycles after the last glitch edge is synchronized.
REQ-034 Switch[1] and Switch[6] pressed on the same edge -> PressPulse bits 1 and 6 high in the same cycle; Pressed=8'h42.
REQ-035 Rst pulsed while Switch[2] held with Pressed[2]=1 -> all outputs 0 on the next cycle; Pressed[2] re-asserts 18 cycles after Rst falls.
REQ-036 BUTTON_AUTOREPEAT_EN defined, Switch[4] held 200 cycles after qualification -> PressPulse[4] at qualification, +64, +84, +104, ... up to +184.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM
// state encoding and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  // Bits needed to count up to (largest count - 1).
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification FSM and
// counters. BUTTON_AUTOREPEAT_EN adds the held-button repeat strobe.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int unsigned CW =
    cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Synchronizer stores the already-inverted level, so a cleared
  // flop means "released" and a button held through reset must be
  // re-qualified from scratch.
  logic [1:0]    sync_q;
  logic          act;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prs_d, rel_d, pp_d;
  logic          pressed_q, pp_q, rp_q;

  assign act = sync_q[1];

  // Next-state and debounce counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prs_d   = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          prs_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!act) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (act) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] rpt_q, rpt_d;
  logic          per_q, per_d;
  logic          rpt_fire;

  // Repeat timer: runs only while staying in HELD, first interval
  // is the delay, later intervals the period.
  always_comb begin
    rpt_d    = rpt_q;
    per_d    = per_q;
    rpt_fire = 1'b0;
    if (state_q != HELD || state_d != HELD) begin
      rpt_d = '0;
      per_d = 1'b0;
    end else if (rpt_q == (per_q ? RP_LAST : RD_LAST)) begin
      rpt_fire = 1'b1;
      rpt_d    = '0;
      per_d    = 1'b1;
    end else if (rpt_q != CNT_MAX) begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_q <= '0;
      per_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      per_q <= per_d;
    end
  end

  assign pp_d = prs_d | rpt_fire;
`else
  assign pp_d = prs_d;
`endif

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      pp_q      <= 1'b0;
      rp_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ~switch_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= (state_d == HELD) || (state_d == REL_WAIT);
      pp_q      <= pp_d;
      rp_q      <= rel_d;
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = pp_q;
  assign release_pulse_o = rp_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer; one independent channel per
// Switch bit. Auto-repeat enabled by BUTTON_AUTOREPEAT_EN.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] Switch,
  output logic [NUM_BTN-1:0] Pressed,
  output logic [NUM_BTN-1:0] PressPulse,
  output logic [NUM_BTN-1:0] ReleasePulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i          (Clk),
      .rst_i          (Rst),
      .switch_i       (Switch[i]),
      .pressed_o      (Pressed[i]),
      .press_pulse_o  (PressPulse[i]),
      .release_pulse_o(ReleasePulse[i])
    );
  end

endmodule
